fir_mac_5x5: RTL and testbench
==============================

Name: fir_mac_5x5

Overview:
Downstream consumer of the coefficient loader. Computes one filtered output pixel per clock from a 5x5 pixel window and 25 signed coefficients, using a pipelined multiplier and adder tree. It also delays the video timing signals to match the datapath latency. Coefficients are captured into a shadow register once per frame, at the end of vsync, so a kernel never changes mid-frame. One instance is used per colour channel.

Parameters:
PIX_W, 8, unsigned pixel width
COEFF_W, 16, signed coefficient width
FRAC_BITS, 8, fractional bits of coefficients; gain 1.0 = 1<<FRAC_BITS

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
dv_i  in  1  input data valid
hs_i  in  1  input hsync
vs_i  in  1  input vsync (active high)
win_i  in  25*PIX_W  window; tap k=5*r+c at [PIX_W*k +: PIX_W], unsigned
coeff_i  in  25*COEFF_W  coefficients, same tap order (coeff00 = k0 ... coeff44 = k24), signed
dv_o  out  1  output data valid
hs_o  out  1  delayed hsync
vs_o  out  1  delayed vsync
pix_o  out  PIX_W  filtered, rounded, saturated pixel

Behaviour:
- Reset: async assert clears all pipeline registers and the timing delay line. dv_o, hs_o, vs_o and pix_o go to 0 immediately. The shadow kernel resets to identity: tap 12 = 1<<FRAC_BITS, all other taps 0.
- Shadow update: vs_i is registered. A falling edge (vs_i_dly=1, vs_i=0) loads coeff_i into the shadow on that clock edge. The stage-1 multiply on that same edge uses the old shadow; the new kernel applies from the next cycle. coeff_i is not used anywhere else.
- Pipeline runs every cycle with no stall and no backpressure. Fixed latency LATENCY = 7 cycles from input sample to output.
- S1: 25 products, pixel zero-extended to PIX_W+1 signed times the shadow coefficient. Product width PIX_W+COEFF_W+1 (25 bits at default).
- S2..S6: balanced adder tree, 25->13->7->4->2->1, one registered level per stage, odd terms passed through. Final width ACC_W = PIX_W+COEFF_W+1+5 (30 bits), so no overflow is possible.
- S7: add 2^(FRAC_BITS-1), arithmetic shift right by FRAC_BITS, then saturate: negative -> 0, >2^PIX_W-1 -> 2^PIX_W-1. Result is registered to pix_o.
- dv/hs/vs: a 7-deep shift register, so dv_o(t) = dv_i(t-7) and likewise for hs and vs.
- pix_o is forced to 0 whenever dv_o = 0. The datapath still computes on invalid cycles, but the result is masked.
- Reset deasserted mid-frame: the pipeline restarts empty, and the first 7 cycles output dv_o=0. The identity kernel is used until the next vs falling edge.
- Back-to-back vsync falling edges: each one reloads the shadow, and the last load wins.

Decomposition:
- Shared package fir_pkg: TAPS=25, WIN=5, PIX_W, COEFF_W, FRAC_BITS defaults, ACC_W and LATENCY=7 constants, and the identity-kernel centre index 12.
- One natural sub-module, fir_adder_tree: a registered 25-input signed tree, parameterised on input width, 5 stages.
- The multiply stage, shadow register, timing delay line and round/saturate stay in fir_mac_5x5.

Test Plan:
- Reset, then a flat window of 100 with no vsync edge: identity kernel gives pix_o=100 with dv_o high exactly 7 cycles after dv_i. pix_o=0 while dv_o is low.
- Load a box kernel (all taps 10, FRAC_BITS=8), pulse vs_i 1->0, then a window of all 200: sum 50000, +128 gives 50128, >>8 gives 195, so pix_o=195.
- Negative result: centre tap -256, others 0, window 50 -> pix_o=0 (saturated low). Centre tap 1024, window 100 -> 400, so pix_o=255 (saturated high).
- Change coeff_i mid-frame without a vs falling edge: output kernel unchanged. On the vs falling edge, the sample on that edge uses the old kernel and the sample on the next cycle uses the new one.
- dv_i/hs_i/vs_i random pattern: the outputs equal the inputs delayed by exactly 7 cycles.
- Assert rst for 1 cycle mid-stream: outputs are 0 asynchronously, the pipeline refills with 7 cycles of dv_o=0, and the identity kernel is restored.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and types for the 5x5 FIR filter datapath.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package fir_pkg;

  localparam int WIN           = 5;
  localparam int TAPS          = WIN * WIN;
  localparam int PIX_W_DEF     = 8;
  localparam int COEFF_W_DEF   = 16;
  localparam int FRAC_BITS_DEF = 8;
  // Growth of a 25-input sum: ceil(log2(25)) = 5 extra bits.
  localparam int TREE_GROW     = 5;
  localparam int LATENCY       = 7;
  localparam int CENTER_TAP    = 12;

  // Accumulator width that can hold the full 25-tap sum without overflow.
  function automatic int acc_width(input int pix_w, input int coeff_w);
    return pix_w + coeff_w + 1 + TREE_GROW;
  endfunction

  localparam int ACC_W = acc_width(PIX_W_DEF, COEFF_W_DEF);

  // Video timing bundle carried alongside the datapath.
  typedef struct packed {
    logic dv;
    logic hs;
    logic vs;
  } timing_t;

endpackage

// File: rtl/fir_adder_tree.sv
// Registered balanced adder tree summing 25 signed terms (25->13->7->4->2->1).
// Latency: 5 cycles, one registered level per stage.
// Backpressure: none; a new set of terms is accepted every cycle.
module fir_adder_tree
  import fir_pkg::*;
#(
  parameter int IN_W = 25
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [TAPS*IN_W-1:0]            terms,
  output logic signed [IN_W+TREE_GROW-1:0] sum
);

  localparam int OUT_W  = IN_W + TREE_GROW;
  // One spare zero slot makes every level an even pairing; an odd last
  // term is paired with zero, which is the same as passing it through.
  localparam int SLOTS  = TAPS + 1;
  localparam int HALF   = SLOTS / 2;
  localparam int LEVELS = 5;

  logic signed [OUT_W-1:0] ext [0:SLOTS-1];
  logic signed [OUT_W-1:0] lvl [0:LEVELS-1][0:SLOTS-1];

  // Sign-extend every term to the final width so no level can overflow.
  always_comb begin
    for (int k = 0; k < SLOTS; k++) ext[k] = '0;
    for (int k = 0; k < TAPS; k++) begin
      ext[k] = {{TREE_GROW{terms[IN_W*k+IN_W-1]}}, terms[IN_W*k +: IN_W]};
    end
  end

  // Pairwise reduction, one registered level per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < LEVELS; l++) begin
        for (int i = 0; i < SLOTS; i++) lvl[l][i] <= '0;
      end
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (i < HALF) lvl[0][i] <= ext[2*i] + ext[2*i+1];
        else          lvl[0][i] <= '0;
      end
      for (int l = 1; l < LEVELS; l++) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (i < HALF) lvl[l][i] <= lvl[l-1][2*i] + lvl[l-1][2*i+1];
          else          lvl[l][i] <= '0;
        end
      end
    end
  end

  assign sum = lvl[LEVELS-1][0];

endmodule

// File: rtl/fir_mac_5x5.sv
// 5x5 window FIR: multiply by a per-frame shadow kernel, sum, round, saturate.
// Latency: 7 cycles input to output; dv/hs/vs delayed by the same amount.
// Backpressure: none; free-running pipeline, one pixel in and out per clock.
module fir_mac_5x5
  import fir_pkg::*;
#(
  parameter int PIX_W     = PIX_W_DEF,
  parameter int COEFF_W   = COEFF_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dv_i,
  input  logic                      hs_i,
  input  logic                      vs_i,
  input  logic [TAPS*PIX_W-1:0]     win_i,
  input  logic [TAPS*COEFF_W-1:0]   coeff_i,
  output logic                      dv_o,
  output logic                      hs_o,
  output logic                      vs_o,
  output logic [PIX_W-1:0]          pix_o
);

  localparam int PROD_W = PIX_W + COEFF_W + 1;
  localparam int ACCW   = acc_width(PIX_W, COEFF_W);

  localparam logic signed [COEFF_W-1:0] UNITY    = COEFF_W'(1) << FRAC_BITS;
  localparam logic signed [ACCW-1:0]    RND_HALF = ACCW'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACCW-1:0]    PIX_MAX  = ACCW'((1 << PIX_W) - 1);

  logic                      vs_dly;
  logic                      load;
  logic signed [COEFF_W-1:0] shadow [0:TAPS-1];
  logic [TAPS*PROD_W-1:0]    prod;
  logic signed [ACCW-1:0]    acc;
  logic signed [ACCW-1:0]    rnd;
  logic signed [ACCW-1:0]    shr;
  logic [PIX_W-1:0]          sat;
  timing_t                   tdl [0:LATENCY-1];
  logic [PIX_W-1:0]          pix_q;

  // Kernel swaps only at the end of vsync so a frame never mixes kernels.
  assign load = vs_dly & ~vs_i;

  // Track vsync and capture the incoming kernel on its falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_dly <= 1'b0;
      for (int k = 0; k < TAPS; k++) shadow[k] <= (k == CENTER_TAP) ? UNITY : '0;
    end else begin
      vs_dly <= vs_i;
      if (load) begin
        for (int k = 0; k < TAPS; k++) shadow[k] <= coeff_i[COEFF_W*k +: COEFF_W];
      end
    end
  end

  // Stage 1: unsigned pixel (made non-negative signed) times signed coefficient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= '0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        prod[PROD_W*k +: PROD_W] <=
          PROD_W'($signed({1'b0, win_i[PIX_W*k +: PIX_W]})) * PROD_W'(shadow[k]);
      end
    end
  end

  // Stages 2..6: reduce the 25 products to one sum.
  fir_adder_tree #(
    .IN_W (PROD_W)
  ) u_tree (
    .clk   (clk),
    .rst   (rst),
    .terms (prod),
    .sum   (acc)
  );

  // Round half up, drop the fractional bits, clamp to the pixel range.
  always_comb begin
    rnd = acc + RND_HALF;
    shr = rnd >>> FRAC_BITS;
    if (shr[ACCW-1])        sat = '0;
    else if (shr > PIX_MAX) sat = '1;
    else                    sat = shr[PIX_W-1:0];
  end

  // Timing delay line matching the datapath depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) tdl[i] <= '0;
    end else begin
      tdl[0] <= '{dv: dv_i, hs: hs_i, vs: vs_i};
      for (int i = 1; i < LATENCY; i++) tdl[i] <= tdl[i-1];
    end
  end

  // Stage 7: register the pixel, masked to zero on invalid cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pix_q <= '0;
    else     pix_q <= tdl[LATENCY-2].dv ? sat : '0;
  end

  assign dv_o  = tdl[LATENCY-1].dv;
  assign hs_o  = tdl[LATENCY-1].hs;
  assign vs_o  = tdl[LATENCY-1].vs;
  assign pix_o = pix_q;

endmodule

// File: tb/tb_fir_mac_5x5.sv
// Directed bench for fir_mac_5x5: kernel shadowing, rounding, saturation, timing.
// Latency: checks the 7-cycle input-to-output alignment.
// Backpressure: none exercised; the design has none.
module tb_fir_mac_5x5;
  import fir_pkg::*;

  localparam int PW = 8;
  localparam int CW = 16;

  logic                 clk;
  logic                 rst;
  logic                 dv_i, hs_i, vs_i;
  logic [TAPS*PW-1:0]   win_i;
  logic [TAPS*CW-1:0]   coeff_i;
  logic                 dv_o, hs_o, vs_o;
  logic [PW-1:0]        pix_o;

  int n_cmp = 0;
  int n_bad = 0;

  fir_mac_5x5 #(
    .PIX_W     (PW),
    .COEFF_W   (CW),
    .FRAC_BITS (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dv_i    (dv_i),
    .hs_i    (hs_i),
    .vs_i    (vs_i),
    .win_i   (win_i),
    .coeff_i (coeff_i),
    .dv_o    (dv_o),
    .hs_o    (hs_o),
    .vs_o    (vs_o),
    .pix_o   (pix_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [TAPS*PW-1:0] flat_win(input logic [PW-1:0] v);
    logic [TAPS*PW-1:0] r;
    for (int k = 0; k < TAPS; k++) r[PW*k +: PW] = v;
    return r;
  endfunction

  function automatic logic [TAPS*CW-1:0] box_kern(input logic [CW-1:0] c);
    logic [TAPS*CW-1:0] r;
    for (int k = 0; k < TAPS; k++) r[CW*k +: CW] = c;
    return r;
  endfunction

  function automatic logic [TAPS*CW-1:0] centre_kern(input logic [CW-1:0] c);
    logic [TAPS*CW-1:0] r;
    r = '0;
    r[CW*CENTER_TAP +: CW] = c;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // vsync high for one cycle, then low: the second edge loads the kernel.
  task automatic vs_fall(input logic [TAPS*CW-1:0] k);
    coeff_i = k;
    vs_i = 1'b1;
    step();
    vs_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_cmp++; if (dv_o !== 1'b0) begin n_bad++; $display("FAIL reset_dv: got %b want 0", dv_o); end
    n_cmp++; if (hs_o !== 1'b0) begin n_bad++; $display("FAIL reset_hs: got %b want 0", hs_o); end
    n_cmp++; if (vs_o !== 1'b0) begin n_bad++; $display("FAIL reset_vs: got %b want 0", vs_o); end
    n_cmp++; if (pix_o !== 8'd0) begin n_bad++; $display("FAIL reset_pix: got %0d want 0", pix_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Identity kernel out of reset; an unloaded box kernel on coeff_i must be ignored.
  task automatic test_identity();
    win_i = flat_win(8'd100);
    coeff_i = box_kern(16'd10);
    repeat (3) step();
    dv_i = 1'b1;
    for (int s = 1; s <= 7; s++) begin
      step();
      if (s < 7) begin
        n_cmp++; if (dv_o !== 1'b0) begin n_bad++; $display("FAIL ident_dv_early[%0d]: got %b want 0", s, dv_o); end
        n_cmp++; if (pix_o !== 8'd0) begin n_bad++; $display("FAIL ident_pix_masked[%0d]: got %0d want 0", s, pix_o); end
      end else begin
        n_cmp++; if (dv_o !== 1'b1) begin n_bad++; $display("FAIL ident_dv: got %b want 1", dv_o); end
        n_cmp++; if (pix_o !== 8'd100) begin n_bad++; $display("FAIL ident_pix: got %0d want 100", pix_o); end
      end
    end
  endtask

  task automatic test_box();
    win_i = flat_win(8'd200);
    vs_fall(box_kern(16'd10));
    repeat (7) step();
    n_cmp++; if (pix_o !== 8'd195) begin n_bad++; $display("FAIL box_pix: got %0d want 195", pix_o); end
    n_cmp++; if (dv_o !== 1'b1) begin n_bad++; $display("FAIL box_dv: got %b want 1", dv_o); end
  endtask

  task automatic test_saturation();
    win_i = flat_win(8'd50);
    vs_fall(centre_kern(16'hFF00));
    repeat (7) step();
    n_cmp++; if (pix_o !== 8'd0) begin n_bad++; $display("FAIL sat_low: got %0d want 0", pix_o); end
    win_i = flat_win(8'd100);
    vs_fall(centre_kern(16'd1024));
    repeat (7) step();
    n_cmp++; if (pix_o !== 8'd255) begin n_bad++; $display("FAIL sat_high: got %0d want 255", pix_o); end
  endtask

  task automatic test_midframe();
    win_i = flat_win(8'd200);
    vs_fall(centre_kern(16'd256));
    repeat (7) step();
    n_cmp++; if (pix_o !== 8'd200) begin n_bad++; $display("FAIL mid_base: got %0d want 200", pix_o); end
    coeff_i = box_kern(16'd10);
    repeat (8) step();
    n_cmp++; if (pix_o !== 8'd200) begin n_bad++; $display("FAIL mid_nochange: got %0d want 200", pix_o); end
    vs_i = 1'b1;
    step();
    vs_i = 1'b0;
    step();          // sample A captured on the loading edge
    step();          // sample B captured one cycle later
    repeat (5) step();
    n_cmp++; if (pix_o !== 8'd200) begin n_bad++; $display("FAIL mid_edge_old: got %0d want 200", pix_o); end
    step();
    n_cmp++; if (pix_o !== 8'd195) begin n_bad++; $display("FAIL mid_edge_new: got %0d want 195", pix_o); end
  endtask

  task automatic test_back_to_back();
    win_i = flat_win(8'd200);
    vs_fall(centre_kern(16'd1024));
    vs_fall(box_kern(16'd10));
    repeat (7) step();
    n_cmp++; if (pix_o !== 8'd195) begin n_bad++; $display("FAIL b2b_last_wins: got %0d want 195", pix_o); end
  endtask

  task automatic test_timing();
    logic [2:0] pat [0:23];
    logic [2:0] got;
    pat = '{3'b100, 3'b110, 3'b001, 3'b000, 3'b111, 3'b101, 3'b010, 3'b011,
            3'b100, 3'b100, 3'b000, 3'b110, 3'b001, 3'b111, 3'b010, 3'b101,
            3'b000, 3'b011, 3'b100, 3'b110, 3'b000, 3'b001, 3'b101, 3'b010};
    win_i = flat_win(8'd77);
    for (int i = 0; i < 24; i++) begin
      {dv_i, hs_i, vs_i} = pat[i];
      step();
      if (i >= 6) begin
        got = {dv_o, hs_o, vs_o};
        n_cmp++; if (got !== pat[i-6]) begin n_bad++; $display("FAIL timing[%0d]: got %b want %b", i, got, pat[i-6]); end
        if (!pat[i-6][2]) begin
          n_cmp++; if (pix_o !== 8'd0) begin n_bad++; $display("FAIL timing_mask[%0d]: got %0d want 0", i, pix_o); end
        end
      end
    end
    {dv_i, hs_i, vs_i} = 3'b100;
  endtask

  task automatic test_reset_midstream();
    win_i = flat_win(8'd100);
    dv_i = 1'b1;
    hs_i = 1'b1;
    vs_fall(box_kern(16'd10));
    repeat (7) step();
    n_cmp++; if (pix_o !== 8'd98) begin n_bad++; $display("FAIL rst_pre_pix: got %0d want 98", pix_o); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (dv_o !== 1'b0) begin n_bad++; $display("FAIL rst_async_dv: got %b want 0", dv_o); end
    n_cmp++; if (hs_o !== 1'b0) begin n_bad++; $display("FAIL rst_async_hs: got %b want 0", hs_o); end
    n_cmp++; if (pix_o !== 8'd0) begin n_bad++; $display("FAIL rst_async_pix: got %0d want 0", pix_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 1; s <= 7; s++) begin
      step();
      if (s < 7) begin
        n_cmp++; if (dv_o !== 1'b0) begin n_bad++; $display("FAIL rst_refill_dv[%0d]: got %b want 0", s, dv_o); end
      end else begin
        n_cmp++; if (dv_o !== 1'b1) begin n_bad++; $display("FAIL rst_refill_dv_on: got %b want 1", dv_o); end
        n_cmp++; if (pix_o !== 8'd100) begin n_bad++; $display("FAIL rst_identity_pix: got %0d want 100", pix_o); end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    dv_i = 1'b0;
    hs_i = 1'b0;
    vs_i = 1'b0;
    win_i = '0;
    coeff_i = '0;
    #1;
    test_reset();
    test_identity();
    test_box();
    test_saturation();
    test_midframe();
    test_back_to_back();
    test_timing();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
